// File: rtl/wash_cycle_sequencer.sv
// wash_cycle_sequencer: coin-operated washer/dryer program controller.
// Takes quarter/dollar credit, validates the selected mode, then steps the
// wash/rinse/spin or dry stages on the 1 Hz tick and drives LEDs and time_left.
// Optional build macro: CREDIT_CARRY_EN (keep unspent credit after a start).
module wash_cycle_sequencer #(
   parameter int PRICE_DEL  = 4,
   parameter int PRICE_NRM  = 6,
   parameter int PRICE_PWR  = 8,
   parameter int PRICE_DRY  = 4,
   parameter int T_WASH_DEL = 3,
   parameter int T_WASH_NRM = 4,
   parameter int T_WASH_PWR = 5,
   parameter int T_RINSE    = 2,
   parameter int T_SPIN     = 1,
   parameter int T_DRY      = 6
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic        tick,
   input  logic [5:0]  SW,
   input  logic        BTNU,
   input  logic        BTND,
   output logic [15:0] LED,
   output logic [7:0]  time_left,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE, S_PAY, S_WASH, S_RINSE, S_SPIN, S_DRY, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  credit_q, credit_d;
   logic [3:0]  mode_q, mode_d;
   logic [3:0]  timer_q, timer_d;
   logic [7:0]  tl_q, tl_d;
   logic        entry_q, entry_d;
   logic [2:0]  stage_led_q, stage_led_d;
   logic        btnu_q, btnd_q;
   logic [15:0] led_q, led_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        coin_up, coin_dn, mode_valid, cnt_tick;
   logic [4:0]  coin_add, credit_sat, price;
   logic [5:0]  credit_sum;
   logic [7:0]  tl_load;
   logic [3:0]  wash_len;

   // Coin edges, saturating credit sum, price and program length of the selected mode
   always_comb begin
      coin_up    = BTNU & ~btnu_q;
      coin_dn    = BTND & ~btnd_q;
      coin_add   = {2'b00, coin_dn, 1'b0, coin_up};
      credit_sum = {1'b0, credit_q} + {1'b0, coin_add};
      credit_sat = credit_sum[5] ? 5'd31 : credit_sum[4:0];
      mode_valid = $onehot(SW[4:1]);
      price      = 5'd0;
      tl_load    = 8'd0;
      case (SW[4:1])
         4'b0001: begin price = 5'(PRICE_DEL); tl_load = 8'(T_WASH_DEL + T_RINSE + T_SPIN); end
         4'b0010: begin price = 5'(PRICE_NRM); tl_load = 8'(T_WASH_NRM + T_RINSE + T_SPIN); end
         4'b0100: begin price = 5'(PRICE_PWR); tl_load = 8'(T_WASH_PWR + T_RINSE + T_SPIN); end
         4'b1000: begin price = 5'(PRICE_DRY); tl_load = 8'(T_DRY); end
         default: begin price = 5'd0; tl_load = 8'd0; end
      endcase
      // wash length comes from the latched mode so switch changes mid-run are harmless
      case (mode_q)
         4'b0001: wash_len = 4'(T_WASH_DEL);
         4'b0100: wash_len = 4'(T_WASH_PWR);
         default: wash_len = 4'(T_WASH_NRM);
      endcase
      // ticks in a stage's first cycle are ignored; the timer is loaded then
      cnt_tick = tick & ~SW[5] & ~entry_q;
   end

   // Next-state, credit, timer and registered-output computation
   always_comb begin
      state_d     = state_q;
      credit_d    = credit_q;
      mode_d      = mode_q;
      timer_d     = timer_q;
      tl_d        = tl_q;
      stage_led_d = stage_led_q;
      case (state_q)
         S_IDLE: begin
            if (coin_up | coin_dn) begin
               state_d  = S_PAY;
               credit_d = credit_sat;
            end
         end
         S_PAY: begin
            if (SW[0]) begin
               credit_d = 5'd0;
               state_d  = S_IDLE;
            end else if (mode_valid && (credit_q >= price)) begin
               mode_d  = SW[4:1];
               tl_d    = tl_load;
               state_d = SW[4] ? S_DRY : S_WASH;
`ifdef CREDIT_CARRY_EN
               credit_d = credit_sat - price;
`else
               credit_d = 5'd0;
`endif
            end else begin
               credit_d = credit_sat;
            end
         end
         S_WASH, S_RINSE, S_SPIN, S_DRY: begin
            if (entry_q) begin
               case (state_q)
                  S_WASH:  timer_d = wash_len;
                  S_RINSE: timer_d = 4'(T_RINSE);
                  S_SPIN:  timer_d = 4'(T_SPIN);
                  default: timer_d = 4'(T_DRY);
               endcase
            end else if (cnt_tick) begin
               timer_d = timer_q - 4'd1;
               tl_d    = tl_q - 8'd1;
               if (timer_q == 4'd1) begin
                  case (state_q)
                     S_WASH:  begin state_d = S_RINSE; stage_led_d[0] = 1'b1; end
                     S_RINSE: begin state_d = S_SPIN;  stage_led_d[1] = 1'b1; end
                     S_SPIN:  begin state_d = S_DONE;  stage_led_d[2] = 1'b1; end
                     default: state_d = S_DONE;
                  endcase
               end
            end
         end
         S_DONE: begin
            if (SW[4:1] == 4'b0000) begin
               state_d     = S_IDLE;
               stage_led_d = 3'b000;
            end
         end
         default: state_d = S_IDLE;
      endcase
      entry_d = (state_d != state_q);
      busy_d  = (state_d == S_WASH) || (state_d == S_RINSE) ||
                (state_d == S_SPIN) || (state_d == S_DRY);
      done_d  = (state_d == S_DONE);
      led_d        = 16'd0;
      led_d[0]     = (state_d == S_DRY);
      led_d[3:1]   = stage_led_d;
      led_d[4]     = done_d;
      led_d[9:5]   = credit_d;
      led_d[10]    = (state_d == S_WASH);
      led_d[11]    = (state_d == S_RINSE);
      led_d[12]    = (state_d == S_SPIN);
      led_d[15]    = SW[5] & busy_d;
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state_q     <= S_IDLE;
         credit_q    <= 5'd0;
         mode_q      <= 4'd0;
         timer_q     <= 4'd0;
         tl_q        <= 8'd0;
         entry_q     <= 1'b0;
         stage_led_q <= 3'd0;
         btnu_q      <= 1'b0;
         btnd_q      <= 1'b0;
         led_q       <= 16'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         mode_q      <= mode_d;
         timer_q     <= timer_d;
         tl_q        <= tl_d;
         entry_q     <= entry_d;
         stage_led_q <= stage_led_d;
         btnu_q      <= BTNU;
         btnd_q      <= BTND;
         led_q       <= led_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign LED       = led_q;
   assign time_left = tl_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed testbench for wash_cycle_sequencer. Inputs change and outputs are
// sampled on the falling edge; the design registers on the rising edge.
module tb_wash_cycle_sequencer;

`ifdef CREDIT_CARRY_EN
   localparam bit CARRY = 1'b1;
`else
   localparam bit CARRY = 1'b0;
`endif

   logic        CLK100MHZ = 1'b0;
   logic        CPU_RESETN = 1'b0;
   logic        tick = 1'b0;
   logic [5:0]  SW = 6'd0;
   logic        BTNU = 1'b0;
   logic        BTND = 1'b0;
   logic [15:0] LED;
   logic [7:0]  time_left;
   logic        busy;
   logic        done;

   int n_chk  = 0;
   int n_pass = 0;

   wash_cycle_sequencer dut (
      .CLK100MHZ (CLK100MHZ),
      .CPU_RESETN(CPU_RESETN),
      .tick      (tick),
      .SW        (SW),
      .BTNU      (BTNU),
      .BTND      (BTND),
      .LED       (LED),
      .time_left (time_left),
      .busy      (busy),
      .done      (done)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   task automatic cyc(input int n);
      repeat (n) @(negedge CLK100MHZ);
   endtask

   // one idle cycle (covers a stage entry cycle) then a one-cycle tick
   task automatic do_tick(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(1);
         tick = 1'b1;
         cyc(1);
         tick = 1'b0;
      end
   endtask

   task automatic pulse_u();
      BTNU = 1'b1; cyc(1); BTNU = 1'b0; cyc(1);
   endtask

   task automatic pulse_d();
      BTND = 1'b1; cyc(1); BTND = 1'b0; cyc(1);
   endtask

   task automatic test_reset();
      CPU_RESETN = 1'b0; SW = 6'd0; cyc(2);
      n_chk++; if (LED !== 16'd0) $display("FAIL reset_led got %h want 0000", LED); else n_pass++;
      n_chk++; if (time_left !== 8'd0) $display("FAIL reset_tl got %0d want 0", time_left); else n_pass++;
      n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      n_chk++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
      CPU_RESETN = 1'b1; cyc(1);
   endtask

   task automatic test_normal_wash();
      SW = 6'b000100;
      pulse_d();
      n_chk++; if (LED[9:5] !== 5'd4) $display("FAIL nrm_credit4 got %0d want 4", LED[9:5]); else n_pass++;
      pulse_u();
      BTNU = 1'b1; cyc(1);
      n_chk++; if (LED[9:5] !== 5'd6) $display("FAIL nrm_credit6 got %0d want 6", LED[9:5]); else n_pass++;
      BTNU = 1'b0; cyc(1);
      n_chk++; if (time_left !== 8'd7) $display("FAIL nrm_tl_load got %0d want 7", time_left); else n_pass++;
      n_chk++; if (busy !== 1'b1 || LED[12:10] !== 3'b001) $display("FAIL nrm_wash busy %b led12_10 %b want 1 001", busy, LED[12:10]); else n_pass++;
      do_tick(4);
      n_chk++; if (LED[1] !== 1'b1 || LED[12:10] !== 3'b010) $display("FAIL nrm_rinse led1 %b led12_10 %b want 1 010", LED[1], LED[12:10]); else n_pass++;
      n_chk++; if (time_left !== 8'd3) $display("FAIL nrm_tl_rinse got %0d want 3", time_left); else n_pass++;
      do_tick(3);
      n_chk++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL nrm_done done %b busy %b want 1 0", done, busy); else n_pass++;
      n_chk++; if (LED[4:1] !== 4'b1111 || time_left !== 8'd0) $display("FAIL nrm_done_led led4_1 %b tl %0d want 1111 0", LED[4:1], time_left); else n_pass++;
      SW = 6'd0; cyc(1);
      n_chk++; if (done !== 1'b0 || LED !== 16'd0) $display("FAIL nrm_idle done %b led %h want 0 0000", done, LED); else n_pass++;
   endtask

   task automatic test_dryer_pause();
      SW = 6'b010000;
      pulse_d();
      n_chk++; if (LED[0] !== 1'b1 || time_left !== 8'd6) $display("FAIL dry_start led0 %b tl %0d want 1 6", LED[0], time_left); else n_pass++;
      SW = 6'b110000;
      do_tick(3);
      n_chk++; if (time_left !== 8'd6) $display("FAIL dry_pause_tl got %0d want 6", time_left); else n_pass++;
      n_chk++; if (LED[15] !== 1'b1 || LED[0] !== 1'b1) $display("FAIL dry_pause_led led15 %b led0 %b want 1 1", LED[15], LED[0]); else n_pass++;
      SW = 6'b010000;
      do_tick(5);
      n_chk++; if (time_left !== 8'd1 || busy !== 1'b1) $display("FAIL dry_tl1 tl %0d busy %b want 1 1", time_left, busy); else n_pass++;
      do_tick(1);
      n_chk++; if (done !== 1'b1 || LED[0] !== 1'b0 || time_left !== 8'd0) $display("FAIL dry_done done %b led0 %b tl %0d want 1 0 0", done, LED[0], time_left); else n_pass++;
      cyc(2);
      n_chk++; if (done !== 1'b1) $display("FAIL dry_done_hold got %b want 1", done); else n_pass++;
      SW = 6'd0; cyc(1);
      n_chk++; if (LED[4:0] !== 5'd0 || done !== 1'b0) $display("FAIL dry_idle led4_0 %b done %b want 0 0", LED[4:0], done); else n_pass++;
   endtask

   task automatic test_cancel();
      SW = 6'd0;
      pulse_u(); pulse_u(); pulse_u();
      n_chk++; if (LED[9:5] !== 5'd3) $display("FAIL cancel_credit3 got %0d want 3", LED[9:5]); else n_pass++;
      SW = 6'b000001; cyc(1);
      n_chk++; if (LED[9:5] !== 5'd0 || busy !== 1'b0) $display("FAIL cancel_clear credit %0d busy %b want 0 0", LED[9:5], busy); else n_pass++;
      SW = 6'd0; cyc(1);
   endtask

   task automatic test_reset_mid_dry();
      SW = 6'b010000;
      pulse_d();
      do_tick(3);
      n_chk++; if (time_left !== 8'd3) $display("FAIL mid_tl3 got %0d want 3", time_left); else n_pass++;
      CPU_RESETN = 1'b0; cyc(1);
      n_chk++; if (LED !== 16'd0 || time_left !== 8'd0 || busy !== 1'b0) $display("FAIL mid_reset led %h tl %0d busy %b want 0000 0 0", LED, time_left, busy); else n_pass++;
      CPU_RESETN = 1'b1; SW = 6'd0; cyc(1);
   endtask

   task automatic test_dual_coin();
      SW = 6'd0;
      BTNU = 1'b1; BTND = 1'b1; cyc(1);
      BTNU = 1'b0; BTND = 1'b0;
      n_chk++; if (LED[9:5] !== 5'd5) $display("FAIL dual_credit got %0d want 5", LED[9:5]); else n_pass++;
      SW = 6'b000110; cyc(2);
      n_chk++; if (busy !== 1'b0 || LED[9:5] !== 5'd5) $display("FAIL dual_invalid busy %b credit %0d want 0 5", busy, LED[9:5]); else n_pass++;
      SW = 6'b000010; cyc(1);
      n_chk++; if (busy !== 1'b1 || time_left !== 8'd6) $display("FAIL dual_start busy %b tl %0d want 1 6", busy, time_left); else n_pass++;
      pulse_u(); pulse_d();
      n_chk++; if (LED[9:5] !== (CARRY ? 5'd1 : 5'd0)) $display("FAIL wash_coin_ignored got %0d want %0d", LED[9:5], CARRY ? 1 : 0); else n_pass++;
      n_chk++; if (time_left !== 8'd6) $display("FAIL wash_coin_tl got %0d want 6", time_left); else n_pass++;
      do_tick(6);
      n_chk++; if (done !== 1'b1 || LED[3:1] !== 3'b111) $display("FAIL dual_done done %b led3_1 %b want 1 111", done, LED[3:1]); else n_pass++;
      SW = 6'd0; cyc(1);
   endtask

   task automatic test_carry();
      CPU_RESETN = 1'b0; SW = 6'd0; cyc(1); CPU_RESETN = 1'b1; cyc(1);
      pulse_d(); pulse_u(); pulse_u(); pulse_u();
      n_chk++; if (LED[9:5] !== 5'd7) $display("FAIL carry_credit7 got %0d want 7", LED[9:5]); else n_pass++;
      SW = 6'b000010; cyc(1);
      n_chk++; if (LED[9:5] !== (CARRY ? 5'd3 : 5'd0)) $display("FAIL carry_start got %0d want %0d", LED[9:5], CARRY ? 3 : 0); else n_pass++;
      do_tick(6);
      SW = 6'd0; cyc(1);
      n_chk++; if (LED[9:5] !== (CARRY ? 5'd3 : 5'd0) || done !== 1'b0) $display("FAIL carry_idle credit %0d done %b want %0d 0", LED[9:5], done, CARRY ? 3 : 0); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_normal_wash();
      test_dryer_pause();
      test_cancel();
      test_reset_mid_dry();
      test_dual_coin();
      test_carry();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wash_cycle_sequencer.md
Name: wash_cycle_sequencer

Overview:
- Top-level program controller for the washer/dryer timer.
- Accepts coin credit, validates the selected mode, then sequences the wash/rinse/spin or dry stages off the 1 Hz slow-clock tick.
- Drives the stage LEDs and the remaining-time value shown on the minute digit display.
- Sits between the board switches/buttons and the display/digit-counter path.

Parameters:
- PRICE_DEL, 4, delicates price in quarters
- PRICE_NRM, 6, normal wash price in quarters
- PRICE_PWR, 8, power wash price in quarters
- PRICE_DRY, 4, dryer price in quarters
- T_WASH_DEL, 3, delicates wash stage length in ticks
- T_WASH_NRM, 4, normal wash stage length in ticks
- T_WASH_PWR, 5, power wash stage length in ticks
- T_RINSE, 2, rinse stage length in ticks
- T_SPIN, 1, spin stage length in ticks
- T_DRY, 6, dry stage length in ticks

Ports:
- CLK100MHZ  in  1  system clock
- CPU_RESETN  in  1  synchronous active-low reset
- tick  in  1  slow-clock pulse, one CLK100MHZ cycle wide
- SW  in  6  SW[0] cancel, SW[1] delicates, SW[2] normal, SW[3] power, SW[4] dryer, SW[5] pause/door open
- BTNU  in  1  quarter inserted; level, already synchronised
- BTND  in  1  dollar inserted; level, already synchronised
- LED  out  16  status LEDs
- time_left  out  8  total ticks remaining in the program, binary
- busy  out  1  program running (WASH/RINSE/SPIN/DRY)
- done  out  1  program complete

Behaviour:
- Reset (CPU_RESETN=0 at a clock edge):
  - state=IDLE, credit=0, LED=0, time_left=0, busy=0, done=0, mode register=0.
  - Reset mid-program aborts immediately and loses all credit.
- Mode validity: exactly one of SW[4:1] high. Zero or several high means invalid.
- Coin handling:
  - Rising-edge detect BTNU (+1 quarter) and BTND (+4 quarters).
  - Coins are accepted only in IDLE and PAY.
  - Both edges in the same cycle add +5.
  - 5-bit credit saturates at 31.
- FSM states: IDLE, PAY, WASH, RINSE, SPIN, DRY, DONE.
  - IDLE -> PAY on the first coin edge. Credit is applied on that edge.
  - PAY:
    - Price tracks the current valid mode each cycle.
    - SW[0]=1: credit cleared, go to IDLE.
    - Valid mode and credit >= price: latch mode, clear credit (excess discarded), load time_left, then go to WASH (washer modes) or DRY (dryer) on the next cycle.
    - Invalid mode: hold in PAY and keep credit.
  - Stage timer:
    - Loaded with the stage length on entry.
    - Decrements on each tick while SW[5]=0.
    - On a tick with timer==1, go to the next stage on the following cycle.
    - A tick in the entry cycle is not counted.
  - Washer sequence: WASH -> RINSE -> SPIN -> DONE.
  - Dryer sequence: DRY -> DONE.
  - time_left:
    - Washer load value = T_WASH_x + T_RINSE + T_SPIN.
    - Dryer load value = T_DRY.
    - Decrements with each counted tick and reaches 0 on entry to DONE.
  - SW[5]=1 freezes the stage timer and time_left. Ticks are ignored and no stage change occurs.
  - During WASH/RINSE/SPIN/DRY: mode switches, SW[0] and coins are ignored, because the mode is latched.
  - DONE: done=1. Hold until SW[4:1] are all 0, then go to IDLE with done=0 and LED[4:0]=0.
- LED map:
  - LED[0]=1 in DRY.
  - LED[1] set on WASH exit.
  - LED[2] set on RINSE exit.
  - LED[3] set on SPIN exit.
  - LED[4]=done.
  - LED[9:5]=credit.
  - LED[12:10]=one-hot running stage: wash, rinse, spin.
  - LED[15]=SW[5] && busy.
  - LED[1:3] stay set until DONE->IDLE.
- busy=1 exactly in WASH/RINSE/SPIN/DRY.
- All outputs registered; one-cycle latency from any input to output.

Optional Feature:
- CREDIT_CARRY_EN:
  - Defined: on program start, credit -= price. The remainder is kept and shown on LED[9:5], and the next program can use it.
  - Undefined: credit is cleared to 0 on start.

Test Plan:
- Reset during DRY with time_left=3 -> next cycle: state IDLE, LED=0, time_left=0, busy=0.
- SW[2]=1, BTND, then BTNU x2 -> credit 6, enters WASH, time_left=7. After 4 ticks: RINSE, LED[1]=1. After 7 ticks total: DONE, done=1, LED[3:1]=3'b111.
- SW[4]=1, BTND -> DRY, LED[0]=1, time_left=6. Raise SW[5] for 3 ticks -> time_left stays 6. Drop SW[5], 6 ticks -> DONE.
- BTNU and BTND rising in the same cycle in IDLE -> PAY, credit=5. SW[1]&SW[2] both high -> stays in PAY. Set SW[1] alone -> WASH, time_left=6.
- In PAY with credit 3, SW[0]=1 -> IDLE, credit=0. Coins during WASH -> credit unchanged.
- CREDIT_CARRY_EN defined: SW[1], credit 7 -> WASH with LED[9:5]=3. Undefined: LED[9:5]=0.
